// File: rtl/jk_excite_if.sv
// Load handshake, feedback and status bundle for jk_excite_driver.
// The driver connects through the slave modport. The stimulus side,
// which feeds q back from the flop under test, uses the master modport.
interface jk_excite_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             q_fb;
    logic             j;
    logic             k;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] err_count;

    modport master (
        output load_valid, load_data, q_fb,
        input  load_ready, j, k, busy, done, err, err_count
    );

    modport slave (
        input  load_valid, load_data, q_fb,
        output load_ready, j, k, busy, done, err, err_count
    );
endinterface

// File: rtl/jk_excite_driver.sv
// J/K excitation driver for characterising a master-slave JK flip-flop.
// The driver serialises a target word LSB-first as per-cycle J/K values.
// It tracks the state the flop is meant to reach and compares the q fed
// back from the flop after FB_LAT cycles. It counts mismatches until the
// count saturates at WIDTH.
module jk_excite_driver #(
    parameter int WIDTH       = 8,
    parameter int FB_LAT      = 2,
    parameter int TOGGLE_MODE = 0
) (
    input logic        clk,
    input logic        rst_n,
    jk_excite_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DRN_W = $clog2(FB_LAT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(FB_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              exp_bit_q, exp_bit_d;
    logic [DRN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic              j_q, j_d;
    logic              k_q, k_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [FB_LAT-1:0] pipe_bit_q, pipe_bit_d;
    logic [FB_LAT-1:0] pipe_vld_q, pipe_vld_d;

    logic push_en;
    logic push_bit;
    logic push_vld;
    logic cur_bit;
    logic chk_en;
    logic mismatch;

    // Next-state, excitation, expected-value pipeline and checking logic
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        idx_d       = idx_q;
        exp_bit_d   = exp_bit_q;
        drain_cnt_d = drain_cnt_q;
        j_d         = 1'b0;
        k_d         = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        pipe_bit_d  = pipe_bit_q;
        pipe_vld_d  = pipe_vld_q;
        push_en     = 1'b0;
        push_bit    = 1'b0;
        push_vld    = 1'b0;

        cur_bit  = data_q[idx_q];
        // The oldest pipeline entry is the bit whose effect q_fb shows now.
        chk_en   = (state_q != IDLE) && pipe_vld_q[FB_LAT-1];
        mismatch = chk_en && (pipe_bit_q[FB_LAT-1] != bus.q_fb);

        if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != CNT_MAX) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    data_d     = bus.load_data;
                    // Start from the flop's actual state, not the last target.
                    exp_bit_d  = bus.q_fb;
                    err_d      = 1'b0;
                    err_cnt_d  = '0;
                    idx_d      = '0;
                    pipe_vld_d = '0;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                if (cur_bit != exp_bit_q) begin
                    if (TOGGLE_MODE != 0) begin
                        j_d = 1'b1;
                        k_d = 1'b1;
                    end else begin
                        j_d = cur_bit;
                        k_d = ~cur_bit;
                    end
                end
                // The intended state advances even if the flop misbehaves.
                exp_bit_d = cur_bit;
                push_en   = 1'b1;
                push_bit  = cur_bit;
                push_vld  = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                push_en = 1'b1;
                if (drain_cnt_q == DRN_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push_en) begin
            pipe_bit_d[0] = push_bit;
            pipe_vld_d[0] = push_vld;
            for (int i = 1; i < FB_LAT; i++) begin
                pipe_bit_d[i] = pipe_bit_q[i-1];
                pipe_vld_d[i] = pipe_vld_q[i-1];
            end
        end
    end

    // Control, excitation and status registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            exp_bit_q   <= 1'b0;
            drain_cnt_q <= '0;
            j_q         <= 1'b0;
            k_q         <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            pipe_bit_q  <= '0;
            pipe_vld_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            exp_bit_q   <= exp_bit_d;
            drain_cnt_q <= drain_cnt_d;
            j_q         <= j_d;
            k_q         <= k_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            pipe_bit_q  <= pipe_bit_d;
            pipe_vld_q  <= pipe_vld_d;
        end
    end

    // Captured target word: pure data, only meaningful after a transfer
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.j          = j_q;
    assign bus.k          = k_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.err_count  = err_cnt_q;
endmodule
